// File: rtl/plot_sequencer.sv
// Owns the VGA plot port for the clear-then-draw job: sequences the fillscreen and
// shape engines with full start/done handshakes and forwards the active engine's pixels.
module plot_sequencer #(
  parameter int   SCREEN_W = 160,
  parameter int   SCREEN_H = 120,
  parameter logic CLEAR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  clear_colour,
  output logic        done,
  output logic        fill_start,
  output logic [2:0]  fill_colour,
  input  logic        fill_done,
  input  logic [7:0]  fill_x,
  input  logic [6:0]  fill_y,
  input  logic [2:0]  fill_col,
  input  logic        fill_plot,
  output logic        shape_start,
  input  logic        shape_done,
  input  logic [7:0]  shape_x,
  input  logic [6:0]  shape_y,
  input  logic [2:0]  shape_col,
  input  logic        shape_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] plot_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CLEAR_REL,
    S_DRAW,
    S_DRAW_REL,
    S_FIN
  } state_t;

  localparam logic [31:0] X_LIMIT = 32'(SCREEN_W);
  localparam logic [31:0] Y_LIMIT = 32'(SCREEN_H);

  state_t      state_q, state_d;
  logic [2:0]  fill_colour_q, fill_colour_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;
  logic [14:0] plot_count_q, plot_count_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d     = state_q;
    fill_start  = 1'b0;
    shape_start = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = CLEAR_EN ? S_CLEAR : S_DRAW;
      end
      S_CLEAR: begin
        fill_start = 1'b1;
        if (fill_done) state_d = S_CLEAR_REL;
      end
      S_CLEAR_REL: begin
        // Waiting for done to drop keeps a stale done from ending the next job early.
        if (!fill_done) state_d = S_DRAW;
      end
      S_DRAW: begin
        shape_start = 1'b1;
        if (shape_done) state_d = S_DRAW_REL;
      end
      S_DRAW_REL: begin
        if (!shape_done) state_d = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel mux: only the engine owning the current phase reaches the adapter, and only on-screen.
  always_comb begin
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    vga_colour_d  = vga_colour_q;
    vga_plot_d    = 1'b0;
    fill_colour_d = accept ? clear_colour : fill_colour_q;
    if (state_q == S_CLEAR) begin
      vga_x_d      = fill_x;
      vga_y_d      = fill_y;
      vga_colour_d = fill_col;
      vga_plot_d   = fill_plot && (32'(fill_x) < X_LIMIT) && (32'(fill_y) < Y_LIMIT);
    end else if (state_q == S_DRAW) begin
      vga_x_d      = shape_x;
      vga_y_d      = shape_y;
      vga_colour_d = shape_col;
      vga_plot_d   = shape_plot && (32'(shape_x) < X_LIMIT) && (32'(shape_y) < Y_LIMIT);
    end
  end

  always_comb begin
    plot_count_d = plot_count_q;
    if (accept) begin
      plot_count_d = '0;
    end else if (vga_plot_q && (plot_count_q != 15'h7FFF)) begin
      plot_count_d = plot_count_q + 15'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fill_colour_q <= '0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      plot_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      fill_colour_q <= fill_colour_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
      plot_count_q  <= plot_count_d;
    end
  end

  assign fill_colour = fill_colour_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;
  assign plot_count  = plot_count_q;

endmodule

// File: tb/tb_plot_sequencer.sv
// Randomized bench for plot_sequencer: engine models drive the pixel buses and a
// pixel-queue scoreboard predicts what the adapter must receive.
module tb_plot_sequencer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [2:0]  clear_colour;
  logic        done, done2;
  logic        fill_start, fill_start2;
  logic [2:0]  fill_colour, fill_colour2;
  logic        fill_done, fill_done2;
  logic [7:0]  fill_x;
  logic [6:0]  fill_y;
  logic [2:0]  fill_col;
  logic        fill_plot;
  logic        shape_start, shape_start2;
  logic        shape_done, shape_done2;
  logic [7:0]  shape_x;
  logic [6:0]  shape_y;
  logic [2:0]  shape_col;
  logic        shape_plot;
  logic [7:0]  vga_x, vga_x2;
  logic [6:0]  vga_y, vga_y2;
  logic [2:0]  vga_colour, vga_colour2;
  logic        vga_plot, vga_plot2;
  logic [14:0] plot_count, plot_count2;

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t exp_q[$];
  logic fill_seen2 = 1'b0;

  always #5 clk = ~clk;

  plot_sequencer #(.SCREEN_W(160), .SCREEN_H(120), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_colour(clear_colour), .done(done),
    .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
    .fill_x(fill_x), .fill_y(fill_y), .fill_col(fill_col), .fill_plot(fill_plot),
    .shape_start(shape_start), .shape_done(shape_done),
    .shape_x(shape_x), .shape_y(shape_y), .shape_col(shape_col), .shape_plot(shape_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .plot_count(plot_count)
  );

  plot_sequencer #(.SCREEN_W(160), .SCREEN_H(120), .CLEAR_EN(1'b0)) dut_noclr (
    .clk(clk), .rst_n(rst_n), .start(start2), .clear_colour(clear_colour), .done(done2),
    .fill_start(fill_start2), .fill_colour(fill_colour2), .fill_done(fill_done2),
    .fill_x(fill_x), .fill_y(fill_y), .fill_col(fill_col), .fill_plot(fill_plot),
    .shape_start(shape_start2), .shape_done(shape_done2),
    .shape_x(shape_x), .shape_y(shape_y), .shape_col(shape_col), .shape_plot(shape_plot),
    .vga_x(vga_x2), .vga_y(vga_y2), .vga_colour(vga_colour2), .vga_plot(vga_plot2),
    .plot_count(plot_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Every forwarded pixel must be the oldest still-expected one.
  always @(negedge clk) begin
    pix_t p;
    if (rst_n && vga_plot) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_plot", 32'(vga_plot), 32'd0);
      end else begin
        p = exp_q.pop_front();
        check_eq("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(p));
      end
    end
  end

  always @(negedge clk) if (fill_start2) fill_seen2 = 1'b1;

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return (int'(x) < 160) && (int'(y) < 120);
  endfunction

  // Engine pixels not owned by the current phase: on-screen and plotting, so leaks show up.
  task automatic drive_junk(input logic fill_j, input logic shape_j);
    fill_x     = 8'($urandom_range(159, 0));
    fill_y     = 7'($urandom_range(119, 0));
    fill_col   = 3'($urandom);
    fill_plot  = fill_j;
    shape_x    = 8'($urandom_range(159, 0));
    shape_y    = 7'($urandom_range(119, 0));
    shape_col  = 3'($urandom);
    shape_plot = shape_j;
  endtask

  // mode 0: full raster clear, 1: random clear with off-screen/idle cycles, 2: all on-screen
  task automatic run_job(input int mode, input int n_fill, input bit pulse,
                         input logic [2:0] col, input bit fixed_shapes, input int abort_at);
    logic [7:0] tx[8] = '{8'd80, 8'd170, 8'd80, 8'd159, 8'd0, 8'd255, 8'd160, 8'd0};
    logic [6:0] ty[8] = '{7'd60, 7'd60, 7'd125, 7'd119, 7'd0, 7'd127, 7'd0, 7'd120};
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    logic       pp;
    int         n_exp = 0;
    int         t;
    int         n_shape;
    int         exp_cnt;

    start = 1'b1;
    clear_colour = col;
    @(negedge clk);
    if (pulse) start = 1'b0;
    t = 0;
    while (!fill_start && t < 8) begin
      @(negedge clk);
      t++;
    end
    check_eq("clear_latency", 32'(t), 32'd0);
    check_eq("fill_colour", 32'(fill_colour), 32'(col));

    for (int i = 0; i < n_fill; i++) begin
      case (mode)
        0: begin px = 8'(i % 160); py = 7'(i / 160); pc = col; pp = 1'b1; end
        1: begin
          px = 8'($urandom_range(200, 0)); py = 7'($urandom_range(127, 0));
          pc = 3'($urandom); pp = ($urandom_range(3, 0) != 0);
        end
        default: begin
          px = 8'($urandom_range(159, 0)); py = 7'($urandom_range(119, 0));
          pc = 3'($urandom); pp = 1'b1;
        end
      endcase
      drive_junk(1'b0, 1'b1);
      fill_x = px; fill_y = py; fill_col = pc; fill_plot = pp;
      fill_done = (i == n_fill - 1);
      if (pp && on_screen(px, py)) begin
        exp_q.push_back('{x: px, y: py, c: pc});
        n_exp++;
      end
      @(negedge clk);
    end
    check_eq("fill_start_fall", 32'(fill_start), 32'd0);

    repeat ($urandom_range(3, 0)) begin
      drive_junk(1'b1, 1'b1);
      check_eq("shape_held_off", 32'(shape_start), 32'd0);
      @(negedge clk);
    end
    fill_done = 1'b0;
    t = 0;
    while (!shape_start && t < 4) begin
      drive_junk(1'b1, 1'b1);
      @(negedge clk);
      t++;
    end
    check_eq("shape_start_rise", 32'(shape_start), 32'd1);

    n_shape = (fixed_shapes ? 8 : 0) + int'($urandom_range(20, 3));
    for (int j = 0; j < n_shape; j++) begin
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("rst_shape_start", 32'(shape_start), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_vga_plot", 32'(vga_plot), 32'd0);
        check_eq("rst_plot_count", 32'(plot_count), 32'd0);
        start = 1'b0; shape_done = 1'b0;
        drive_junk(1'b0, 1'b0);
        $display("[TB] job aborted by reset after %0d shape pixels", j);
        return;
      end
      if (fixed_shapes && j < 8) begin
        px = tx[j]; py = ty[j]; pc = 3'(j); pp = 1'b1;
      end else begin
        px = 8'($urandom_range(175, 0)); py = 7'($urandom_range(127, 0));
        pc = 3'($urandom); pp = ($urandom_range(2, 0) != 0);
      end
      drive_junk(1'b1, 1'b0);
      shape_x = px; shape_y = py; shape_col = pc; shape_plot = pp;
      shape_done = (j == n_shape - 1);
      if (pp && on_screen(px, py)) begin
        exp_q.push_back('{x: px, y: py, c: pc});
        n_exp++;
      end
      @(negedge clk);
    end
    check_eq("shape_start_fall", 32'(shape_start), 32'd0);

    repeat ($urandom_range(3, 0)) begin
      drive_junk(1'b1, 1'b1);
      check_eq("done_early", 32'(done), 32'd0);
      @(negedge clk);
    end
    shape_done = 1'b0;
    drive_junk(1'b1, 1'b1);
    t = 0;
    while (!done && t < 4) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_rise", 32'(done), 32'd1);
    drive_junk(1'b0, 1'b0);
    if (pulse) begin
      @(negedge clk);
      check_eq("done_one_cycle", 32'(done), 32'd0);
    end else begin
      repeat ($urandom_range(4, 1)) begin
        check_eq("done_held", 32'(done), 32'd1);
        @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
      check_eq("done_release", 32'(done), 32'd0);
    end

    exp_cnt = (n_exp > 32767) ? 32767 : n_exp;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("plot_count", 32'(plot_count), 32'(exp_cnt));
    $display("[TB] job mode=%0d fills=%0d pulse=%0d expected=%0d plot_count=%0d",
             mode, n_fill, pulse, exp_cnt, plot_count);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; start2 = 1'b0; clear_colour = 3'b000;
    fill_done = 1'b0; fill_done2 = 1'b0; shape_done = 1'b0; shape_done2 = 1'b0;
    drive_junk(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 32'({done, fill_start, shape_start, vga_plot}), 32'd0);
    check_eq("rst_bus", 32'({vga_x, vga_y, vga_colour, fill_colour}), 32'd0);
    check_eq("rst_count", 32'(plot_count), 32'd0);
    rst_n = 1'b1;

    run_job(0, 19200, 1'b0, 3'b000, 1'b1, -1);
    run_job(1, 300, 1'b1, 3'($urandom), 1'b1, -1);
    run_job(2, 32800, 1'b1, 3'($urandom), 1'b0, -1);
    run_job(1, 150, 1'b0, 3'($urandom), 1'b0, -1);
    run_job(1, 40, 1'b0, 3'($urandom), 1'b1, 5);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(1, 200, 1'b0, 3'($urandom), 1'b1, -1);

    start2 = 1'b1;
    @(negedge clk);
    check_eq("noclr_shape_start", 32'(shape_start2), 32'd1);
    shape_done2 = 1'b1;
    @(negedge clk);
    shape_done2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("noclr_done", 32'(done2), 32'd1);
    start2 = 1'b0;
    @(negedge clk);
    check_eq("noclr_done_fall", 32'(done2), 32'd0);
    check_eq("noclr_fill_never", 32'(fill_seen2), 32'd0);
    $display("[TB] no-clear job colour=%0d count=%0d last=(%0d,%0d,%0d,%0d)",
             fill_colour2, plot_count2, vga_x2, vga_y2, vga_colour2, vga_plot2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_sequencer.md
Name: plot_sequencer

Overview:
- Job controller that owns the single VGA adapter plot port for the Lab 4 drawing path.
- On start, it runs the fillscreen engine to clear the screen, then runs the shape engine (circle or reuleaux), and forwards only the active engine's pixels to the adapter.
- It clips off-screen plots, counts forwarded plots, and gives the top level one start/done handshake for the whole clear-then-draw job.

Parameters:
- SCREEN_W, 160, horizontal pixel count; plots with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, vertical pixel count; plots with y >= SCREEN_H are suppressed.
- CLEAR_EN, 1, when 0 the clear phase is skipped and the job goes straight to the draw phase.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job request, held high until done is seen.
- clear_colour  input  3  colour driven to fillscreen, sampled when the job is accepted.
- done  output  1  job complete, held while start is high.
- fill_start  output  1  start to the fillscreen engine.
- fill_colour  output  3  latched clear_colour.
- fill_done  input  1  fillscreen done.
- fill_x / fill_y / fill_col / fill_plot  input  8/7/3/1  fillscreen pixel bus.
- shape_start  output  1  start to the shape engine.
- shape_done  input  1  shape engine done.
- shape_x / shape_y / shape_col / shape_plot  input  8/7/3/1  shape pixel bus.
- vga_x / vga_y / vga_colour / vga_plot  output  8/7/3/1  registered bus to the VGA adapter.
- plot_count  output  15  plots forwarded in the current job, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - done, fill_start, shape_start, vga_plot all 0.
  - vga_x, vga_y, vga_colour 0; fill_colour 0; plot_count 0.
- Reset asserted mid-job aborts immediately. Engine starts drop in the same reset assertion.
- States: IDLE, CLEAR, CLEAR_REL, DRAW, DRAW_REL, FIN.
- IDLE:
  - start=1 moves to CLEAR if CLEAR_EN=1, otherwise to DRAW.
  - On that edge, latch clear_colour into fill_colour and clear plot_count to 0.
- CLEAR:
  - fill_start=1.
  - When fill_done=1 is sampled, move to CLEAR_REL. fill_start is 0 from the next cycle.
- CLEAR_REL:
  - fill_start=0.
  - Wait for fill_done=0, then move to DRAW. This guarantees a stale done is never taken for the next job.
- DRAW:
  - shape_start=1.
  - When shape_done=1 is sampled, move to DRAW_REL.
- DRAW_REL:
  - shape_start=0.
  - Wait for shape_done=0, then move to FIN.
- FIN:
  - done=1.
  - When start=0 is sampled, done=0 on the next cycle and the state returns to IDLE.
  - If start already dropped during the job, done is high for exactly one cycle.
- start deasserted before FIN is ignored; the job always runs to completion.
- Pixel mux, registered with 1-cycle latency:
  - Each cycle, vga_x/vga_y/vga_colour load from the fill bus in CLEAR and from the shape bus in DRAW.
  - In all other states they hold their value.
  - vga_plot is 1 only when the selected engine's plot=1 and the state is CLEAR or DRAW and x < SCREEN_W and y < SCREEN_H.
  - Plots from the non-selected engine are dropped.
  - Plots are forwarded in the cycle where the state is CLEAR or DRAW; the plot sampled on the same edge that fill_done or shape_done is seen is still forwarded.
- plot_count:
  - Increments by 1 on every cycle in which the registered vga_plot is 1.
  - Saturates at 32767.
  - Holds its value through FIN and IDLE until the next job is accepted.
- Clipped pixels never increment plot_count.
- Widths are fixed: x compares as 8-bit unsigned, y as 7-bit unsigned.

Test Plan:
1. Reset with start=1, then release rst_n → all outputs 0 during reset. The first cycle after release enters CLEAR with fill_start=1 and fill_colour equal to clear_colour (e.g. 3'b000).
2. Model fillscreen that plots 19200 pixels then raises fill_done → vga_plot is high 19200 cycles, each 1 cycle after the fill_plot; plot_count=19200.
   - fill_start falls 1 cycle after fill_done.
   - shape_start rises only after fill_done is low.
3. Model shape engine that plots (80,60), (170,60), (80,125), (159,119) → only (80,60) and (159,119) reach vga_plot=1; plot_count increases by 2.
4. Shape engine asserts shape_plot during CLEAR, and fill_plot during DRAW → vga_plot stays 0 for both.
5. Handshake:
   - start held high through the job → done=1 until start drops, then 0 next cycle and state is IDLE.
   - start pulsed for 1 cycle → done high exactly 1 cycle.
   - With CLEAR_EN=0, fill_start never rises.
6. Assert rst_n low mid-DRAW → done, shape_start and vga_plot go to 0 asynchronously; plot_count goes to 0. A new start after release runs a full clear-then-draw job.
